// File: rtl/data_memory_burst_if.sv
// Request/burst bus between a cache line engine (master) and the burst data memory (slave).
// Carries the valid/ready request, the write beat stream and the read beat stream.
interface data_memory_burst_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              done;

    modport master (
        output req_valid, req_we, req_addr, wr_data,
        input  req_ready, wr_ack, rd_valid, rd_data, done
    );

    modport slave (
        input  req_valid, req_we, req_addr, wr_data,
        output req_ready, wr_ack, rd_valid, rd_data, done
    );
endinterface

// File: rtl/data_memory_burst.sv
// Backing data memory serving whole-line bursts after a fixed access latency.
// Beats wrap within the line starting at the requested word (critical-word-first).
module data_memory_burst #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int LATENCY   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    data_memory_burst_if.slave bus
);
    localparam int OFF_W = $clog2(BURST_LEN);
    localparam int CNT_W = $clog2(BURST_LEN);
    localparam int LAT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              last_beat;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    assign last_beat = (state_q == XFER) && (cnt_q == CNT_W'(BURST_LEN - 1));

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        base_d  = base_q;
        off_d   = off_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    base_d  = bus.req_addr & ~ADDR_W'(BURST_LEN - 1);
                    off_d   = bus.req_addr[OFF_W-1:0];
                    cnt_d   = '0;
                    lat_d   = LAT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? XFER : WAIT;
                end
            end
            WAIT: begin
                if (lat_q <= LAT_W'(1)) begin
                    state_d = XFER;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            XFER: begin
                // Offset add truncates, so the beat address wraps inside the line.
                off_d = off_q + OFF_W'(1);
                cnt_d = cnt_q + CNT_W'(1);
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            base_q  <= '0;
            off_q   <= '0;
            lat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            base_q  <= base_d;
            off_q   <= off_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read one cycle ahead so the registered word lines up with its beat.
    assign rd_en   = (state_d == XFER) && !we_d;
    assign rd_addr = base_d | ADDR_W'(off_d);
    assign wr_en   = (state_q == XFER) && we_q;
    assign wr_addr = base_q | ADDR_W'(off_q);

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.wr_ack    = (state_q == XFER) && we_q;
    assign bus.rd_valid  = (state_q == XFER) && !we_q;
    assign bus.done      = last_beat;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_data_memory_burst.sv
// Randomised self-checking bench: two instances (LATENCY=4/BURST_LEN=4 and LATENCY=1/BURST_LEN=8)
// compared cycle by cycle against a word-array memory model and the burst timing rules.
module tb_data_memory_burst;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    data_memory_burst_if #(.DATA_W(32), .ADDR_W(10)) ifa ();
    data_memory_burst_if #(.DATA_W(32), .ADDR_W(10)) ifb ();

    data_memory_burst #(.DATA_W(32), .ADDR_W(10), .LATENCY(4), .BURST_LEN(4)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa)
    );
    data_memory_burst #(.DATA_W(32), .ADDR_W(10), .LATENCY(1), .BURST_LEN(8)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb)
    );

    logic [31:0] ref_mem [2][1024];
    bit          known   [2][1024];
    int          errors = 0;
    int          checks = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int inst);
        return (inst == 0) ? 4 : 1;
    endfunction

    function automatic int bl_of(input int inst);
        return (inst == 0) ? 4 : 8;
    endfunction

    // {req_ready, wr_ack, rd_valid, done}
    function automatic logic [3:0] ctl_of(input int inst);
        if (inst == 0) return {ifa.req_ready, ifa.wr_ack, ifa.rd_valid, ifa.done};
        return {ifb.req_ready, ifb.wr_ack, ifb.rd_valid, ifb.done};
    endfunction

    function automatic logic [31:0] rd_of(input int inst);
        return (inst == 0) ? ifa.rd_data : ifb.rd_data;
    endfunction

    task automatic drive(input int inst, input logic v, input logic we,
                         input logic [9:0] a, input logic [31:0] wd);
        if (inst == 0) begin
            ifa.req_valid = v; ifa.req_we = we; ifa.req_addr = a; ifa.wr_data = wd;
        end else begin
            ifb.req_valid = v; ifb.req_we = we; ifb.req_addr = a; ifb.wr_data = wd;
        end
    endtask

    // Called at a negedge of a cycle in which the DUT must be idle; returns at the
    // negedge of the first cycle after done (or the cycle after an abort reset).
    task automatic burst(input int inst, input logic we, input logic [9:0] addr,
                         input bit hold, input logic hwe, input logic [9:0] haddr,
                         input int abort_k);
        int lat = lat_of(inst);
        int bl  = bl_of(inst);
        int off = int'(addr) % bl;
        int base = int'(addr) - off;
        int k;
        int ba;
        logic [31:0] wd;
        logic [3:0] exp_ctl;
        drive(inst, 1'b1, we, addr, $urandom);
        check_val($sformatf("accept_ctl i%0d a%03h", inst, addr), ctl_of(inst), 4'b1000);
        for (int i = 1; i < lat + bl; i++) begin
            @(negedge clk);
            k  = i - lat;
            ba = base + ((off + k) % bl);
            wd = $urandom;
            if (hold) drive(inst, 1'b1, hwe, haddr, wd);
            else      drive(inst, 1'b0, 1'b0, 10'h000, wd);
            exp_ctl = {1'b0, we && k >= 0, !we && k >= 0, k == bl - 1};
            check_val($sformatf("ctl i%0d a%03h c%0d", inst, addr, i), ctl_of(inst), exp_ctl);
            if (k >= 0 && !we && known[inst][ba])
                check_val($sformatf("rd i%0d beat%0d @%03h", inst, k, ba), rd_of(inst), ref_mem[inst][ba]);
            if (k == abort_k) begin
                if (inst == 0) rst_a = 1'b1; else rst_b = 1'b1;
                @(negedge clk);
                rst_a = 1'b0;
                rst_b = 1'b0;
                drive(inst, 1'b0, 1'b0, 10'h000, 32'h0);
                check_val($sformatf("abort_ctl i%0d", inst), ctl_of(inst), 4'b1000);
                check_val($sformatf("abort_rd i%0d", inst), rd_of(inst), 0);
                $display("burst inst=%0d we=%0d addr=%03h aborted at beat %0d", inst, we, addr, k);
                return;
            end
            if (k >= 0 && we) begin
                ref_mem[inst][ba] = wd;
                known[inst][ba]   = 1'b1;
            end
        end
        @(negedge clk);
        $display("burst inst=%0d we=%0d addr=%03h hold=%0d", inst, we, addr, hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic       cur_we, nxt_we;
        logic [9:0] cur_addr, nxt_addr;
        bit         hold;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 1'b0, 1'b0, 10'h000, 32'h0);
        drive(1, 1'b0, 1'b0, 10'h000, 32'h0);
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        check_val("reset_ctl a", ctl_of(0), 4'b1000);
        check_val("reset_rd a", rd_of(0), 0);
        check_val("reset_ctl b", ctl_of(1), 4'b1000);
        check_val("reset_rd b", rd_of(1), 0);
        @(negedge clk);

        // Fill every line of instance A, starting each at a random word.
        for (int l = 0; l < 256; l++)
            burst(0, 1'b1, 10'(l * 4 + int'($urandom_range(0, 3))), 1'b0, 1'b0, 10'h0, -1);

        burst(0, 1'b1, 10'h010, 1'b0, 1'b0, 10'h0, -1);
        burst(0, 1'b0, 10'h012, 1'b0, 1'b0, 10'h0, -1);
        burst(0, 1'b1, 10'h3FE, 1'b0, 1'b0, 10'h0, -1);
        burst(0, 1'b0, 10'h3FF, 1'b0, 1'b0, 10'h0, -1);
        burst(0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h0, -1);
        // Request held through a busy burst with a different address.
        burst(0, 1'b1, 10'h040, 1'b1, 1'b0, 10'h123, -1);
        burst(0, 1'b0, 10'h123, 1'b0, 1'b0, 10'h0, -1);

        cur_we   = 1'($urandom_range(0, 1));
        cur_addr = 10'($urandom);
        for (int n = 0; n < 40; n++) begin
            nxt_we   = 1'($urandom_range(0, 1));
            nxt_addr = 10'($urandom);
            hold     = bit'($urandom_range(0, 1));
            burst(0, cur_we, cur_addr, hold, nxt_we, nxt_addr, -1);
            cur_we   = nxt_we;
            cur_addr = nxt_addr;
        end

        // Reset during the second write beat of a burst to 0x020.
        burst(0, 1'b0, 10'h021, 1'b0, 1'b0, 10'h0, -1);
        burst(0, 1'b1, 10'h020, 1'b0, 1'b0, 10'h0, 1);
        burst(0, 1'b0, 10'h020, 1'b0, 1'b0, 10'h0, -1);

        // Instance B: LATENCY=1, BURST_LEN=8.
        for (int l = 0; l < 4; l++)
            burst(1, 1'b1, 10'(l * 8), 1'b0, 1'b0, 10'h0, -1);
        burst(1, 1'b0, 10'h005, 1'b0, 1'b0, 10'h0, -1);
        for (int n = 0; n < 12; n++)
            burst(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), 1'b0, 1'b0, 10'h0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
